// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one combinational RV32I arithmetic unit between
// NUM_REQ requesters and registers the result into a one-entry response stage.
// Ports: clk, rst (async, active-low); req_valid/req_ready and packed
// per-requester payload req_lhs/req_rhs/req_funct3/req_funct7/req_tag;
// alu_lhs/alu_rhs/alu_funct3/alu_funct7 to the unit, alu_result/alu_code_ok
// back; rsp_valid/rsp_ready with rsp_result/rsp_id/rsp_tag/rsp_illegal.
// Config: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// default is round-robin starting after the last granted requester.
module alu_issue_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs,
  input  logic [NUM_REQ*3-1:0]          req_funct3,
  input  logic [NUM_REQ*7-1:0]          req_funct7,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  output logic [DATA_WIDTH-1:0]         alu_lhs,
  output logic [DATA_WIDTH-1:0]         alu_rhs,
  output logic [2:0]                    alu_funct3,
  output logic [6:0]                    alu_funct7,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_code_ok,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  output logic                          rsp_illegal
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic [ID_W-1:0]       r_rsp_id;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic                  r_rsp_illegal;

  logic                  w_accept;
  logic                  w_gnt_any;
  logic [ID_W-1:0]       w_gnt_id;
  logic                  w_hs;
  int                    w_sel;

`ifndef ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]       r_rr_ptr;
`endif

  assign w_accept = !r_rsp_valid || rsp_ready;

  // Grant search. Round-robin starts one past the last winner and wraps.
  always_comb begin
    int idx;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    idx       = 0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = k;
      if (!w_gnt_any && req_valid[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'(idx);
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_gnt_any && req_valid[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'(idx);
      end
    end
`endif
  end

  // rst gates ready so nothing looks accepted while reset is held.
  assign w_hs  = w_gnt_any && w_accept && rst;
  assign w_sel = int'(w_gnt_id);

  always_comb begin
    req_ready = '0;
    if (w_hs) req_ready[w_gnt_id] = 1'b1;
  end

  // With no grant w_gnt_id is 0, so slice 0 feeds the unit.
  assign alu_lhs    = req_lhs[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign alu_rhs    = req_rhs[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign alu_funct3 = req_funct3[w_sel*3 +: 3];
  assign alu_funct7 = req_funct7[w_sel*7 +: 7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_id      <= '0;
      r_rsp_tag     <= '0;
      r_rsp_illegal <= 1'b0;
    end else if (w_hs) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_result  <= alu_code_ok ? alu_result : '0;
      r_rsp_id      <= w_gnt_id;
      r_rsp_tag     <= req_tag[w_sel*TAG_WIDTH +: TAG_WIDTH];
      r_rsp_illegal <= !alu_code_ok;
    end else if (rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Pointer moves only on an accepted request, never on a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (w_hs) begin
      r_rr_ptr <= w_gnt_id;
    end
  end
`endif

  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_id      = r_rsp_id;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed-vector bench for alu_issue_arbiter
// with a small RV32I arithmetic model standing in for the external unit.
module tb_alu_issue_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  vld;
  logic [1:0]  req_ready;
  logic [31:0] lhs [2];
  logic [31:0] rhs [2];
  logic [2:0]  f3  [2];
  logic [6:0]  f7  [2];
  logic [3:0]  tg  [2];
  logic [31:0] alu_lhs;
  logic [31:0] alu_rhs;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_result;
  logic        alu_code_ok;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [0:0]  rsp_id;
  logic [3:0]  rsp_tag;
  logic        rsp_illegal;

  int n_chk;
  int n_fail;

  alu_issue_arbiter #(
    .DATA_WIDTH(32),
    .NUM_REQ(2),
    .TAG_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(vld),
    .req_ready(req_ready),
    .req_lhs({lhs[1], lhs[0]}),
    .req_rhs({rhs[1], rhs[0]}),
    .req_funct3({f3[1], f3[0]}),
    .req_funct7({f7[1], f7[0]}),
    .req_tag({tg[1], tg[0]}),
    .alu_lhs(alu_lhs),
    .alu_rhs(alu_rhs),
    .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7),
    .alu_result(alu_result),
    .alu_code_ok(alu_code_ok),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_id(rsp_id),
    .rsp_tag(rsp_tag),
    .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference RV32I arithmetic unit.
  always_comb begin
    alu_code_ok = (alu_funct7 == 7'h00) ||
                  (alu_funct7 == 7'h20 &&
                   (alu_funct3 == 3'd0 || alu_funct3 == 3'd5));
    alu_result = '0;
    case (alu_funct3)
      3'd0: alu_result = alu_funct7[5] ? alu_lhs - alu_rhs
                                       : alu_lhs + alu_rhs;
      3'd1: alu_result = alu_lhs << alu_rhs[4:0];
      3'd2: alu_result = {31'd0, $signed(alu_lhs) < $signed(alu_rhs)};
      3'd3: alu_result = {31'd0, alu_lhs < alu_rhs};
      3'd4: alu_result = alu_lhs ^ alu_rhs;
      3'd5: alu_result = alu_funct7[5]
                         ? 32'($signed(alu_lhs) >>> alu_rhs[4:0])
                         : alu_lhs >> alu_rhs[4:0];
      3'd6: alu_result = alu_lhs | alu_rhs;
      default: alu_result = alu_lhs & alu_rhs;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] fn3,
                         input logic [6:0] fn7, input logic [3:0] t);
    lhs[i] = a;
    rhs[i] = b;
    f3[i]  = fn3;
    f7[i]  = fn7;
    tg[i]  = t;
    vld[i] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    vld = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_id;
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b0;
    vld = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lhs[i] = '0; rhs[i] = '0; f3[i] = '0; f7[i] = '0; tg[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_tag", 32'(rsp_tag), 32'd0);
    check("rst_illegal", 32'(rsp_illegal), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    // 1: single ADD from requester 0
    @(negedge clk);
    rst = 1'b1;
    vld = 2'b00;
    set_req(0, 32'd5, 32'd3, 3'd0, 7'h00, 4'd2);
    #1;
    check("t1_ready", 32'(req_ready), 32'd1);
    check("t1_alu_lhs", alu_lhs, 32'd5);
    post();
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_result", rsp_result, 32'd8);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_tag", 32'(rsp_tag), 32'd2);
    @(negedge clk);
    vld = 2'b00;
    post();
    check("t1_drain", 32'(rsp_valid), 32'd0);
    check("t1_hold", rsp_result, 32'd8);

    // 2: both valid every cycle
    do_reset();
    set_req(0, 32'd1, 32'd1, 3'd0, 7'h00, 4'd0);
    set_req(1, 32'd2, 32'd2, 3'd0, 7'h00, 4'd1);
    for (int k = 0; k < 4; k++) begin
      post();
`ifdef ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % 2;
`endif
      check("t2_valid", 32'(rsp_valid), 32'd1);
      check("t2_id", 32'(rsp_id), 32'(exp_id));
      check("t2_result", rsp_result, exp_id == 0 ? 32'd2 : 32'd4);
    end
    @(negedge clk);
    vld = 2'b00;
    post();
    check("t2_drain", 32'(rsp_valid), 32'd0);

    // 3: stall with response held
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1, 32'd9, 32'd3, 3'd4, 7'h00, 4'd5);
    post();
    check("t3_result", rsp_result, 32'd10);
    @(negedge clk);
    vld = 2'b00;
    set_req(0, 32'd7, 32'd1, 3'd0, 7'h00, 4'd3);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_stall_ready", 32'(req_ready), 32'd0);
      post();
      check("t3_hold_valid", 32'(rsp_valid), 32'd1);
      check("t3_hold_result", rsp_result, 32'd10);
      check("t3_hold_id", 32'(rsp_id), 32'd1);
      check("t3_hold_tag", 32'(rsp_tag), 32'd5);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("t3_ready", 32'(req_ready), 32'd1);
    post();
    check("t3_new_result", rsp_result, 32'd8);
    check("t3_new_id", 32'(rsp_id), 32'd0);
    check("t3_new_tag", 32'(rsp_tag), 32'd3);
    @(negedge clk);
    vld = 2'b00;

    // 4: illegal op then SUB
    set_req(1, 32'd11, 32'd22, 3'd0, 7'h01, 4'd6);
    post();
    check("t4_illegal", 32'(rsp_illegal), 32'd1);
    check("t4_ill_result", rsp_result, 32'd0);
    check("t4_ill_id", 32'(rsp_id), 32'd1);
    check("t4_ill_tag", 32'(rsp_tag), 32'd6);
    @(negedge clk);
    vld = 2'b00;
    set_req(0, 32'd10, 32'd4, 3'd0, 7'h20, 4'd7);
    post();
    check("t4_sub", rsp_result, 32'd6);
    check("t4_sub_legal", 32'(rsp_illegal), 32'd0);
    check("t4_sub_id", 32'(rsp_id), 32'd0);

    // 5: SRA and SLT
    @(negedge clk);
    vld = 2'b00;
    set_req(1, 32'h8000_0000, 32'd4, 3'd5, 7'h20, 4'd8);
    post();
    check("t5_sra", rsp_result, 32'hF800_0000);
    check("t5_sra_tag", 32'(rsp_tag), 32'd8);
    @(negedge clk);
    vld = 2'b00;
    set_req(0, 32'hFFFF_FFFF, 32'd1, 3'd2, 7'h00, 4'd9);
    post();
    check("t5_slt", rsp_result, 32'd1);

    // 6: async reset with a held response and pending requests
    @(negedge clk);
    rsp_ready = 1'b0;
    vld = 2'b11;
    post();
    check("t6_pre_valid", 32'(rsp_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("t6_first_ready", 32'(req_ready), 32'd1);
    post();
    check("t6_first_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    vld = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
